// File: rtl/data_ram_b_pkg.sv
// Shared sizing for the processor data RAM: word width and word-address width
// used by the interface, the RAM core and its optional output stage.
package data_ram_b_pkg;

    localparam int RAM_DATA_W = 32;
    localparam int RAM_ADDR_W = 6;

    typedef logic [RAM_DATA_W-1:0] word_t;

endpackage : data_ram_b_pkg

// File: rtl/data_ram_b_if.sv
// Single-port RAM bus: write enable, word address and data in, read data out.
interface data_ram_b_if
    import data_ram_b_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
);

    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    modport master (
        output wea,
        output addra,
        output dina,
        input  douta
    );

    modport slave (
        input  wea,
        input  addra,
        input  dina,
        output douta
    );

endinterface : data_ram_b_if

// File: rtl/data_ram_b_outreg.sv
// Optional second read-data pipeline stage; clears asynchronously with the port register.
module data_ram_b_outreg
    import data_ram_b_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] stage_d;
    logic [DATA_W-1:0] stage_q;

    always_comb begin
        stage_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule : data_ram_b_outreg

// File: rtl/data_ram_b.sv
// Processor data memory: 64 x 32 single-port synchronous RAM, write-first,
// registered read data (one cycle, or two with OUT_REG=1).
module data_ram_b
    import data_ram_b_pkg::*;
#(
    parameter int    DATA_W    = RAM_DATA_W,
    parameter int    ADDR_W    = RAM_ADDR_W,
    parameter string INIT_FILE = "",
    parameter int    OUT_REG   = 0
) (
    input logic         clka,
    input logic         rsta_n,
    data_ram_b_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef logic [DEPTH-1:0][DATA_W-1:0] image_t;

    // Power-up contents: every word zero.
    image_t            mem_q = '0;
    logic              wr_ok;
    logic [DATA_W-1:0] douta_d;
    logic [DATA_W-1:0] douta_q;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        wr_ok   = bus.wea && !$isunknown(bus.addra);
        douta_d = bus.wea ? bus.dina : mem_q[bus.addra];
    end

    // NOTE: the array has no reset so it maps onto block RAM and keeps its
    // contents across rsta_n; only the output register is cleared.
    always_ff @(posedge clka) begin
        if (wr_ok) begin
            mem_q[bus.addra] <= bus.dina;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            douta_q <= '0;
        end else begin
            douta_q <= douta_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            data_ram_b_outreg #(
                .DATA_W (DATA_W)
            ) u_outreg (
                .clk   (clka),
                .rst_n (rsta_n),
                .d     (douta_q),
                .q     (bus.douta)
            );
        end else begin : g_no_out_reg
            assign bus.douta = douta_q;
        end
    endgenerate

endmodule : data_ram_b

// File: tb/tb_data_ram_b.sv
// Bench for data_ram_b: scripted scenarios plus random traffic against an array model,
// driving a latency-1 and a latency-2 (OUT_REG=1) instance with identical stimulus.
module tb_data_ram_b;

    logic clka   = 1'b0;
    logic rsta_n = 1'b0;

    always #5 clka = ~clka;

    data_ram_b_if #(.DATA_W(32), .ADDR_W(6)) bus  ();
    data_ram_b_if #(.DATA_W(32), .ADDR_W(6)) bus2 ();

    assign bus2.wea   = bus.wea;
    assign bus2.addra = bus.addra;
    assign bus2.dina  = bus.dina;

    data_ram_b #(.DATA_W(32), .ADDR_W(6), .INIT_FILE(""), .OUT_REG(0)) dut (
        .clka   (clka),
        .rsta_n (rsta_n),
        .bus    (bus)
    );

    data_ram_b #(.DATA_W(32), .ADDR_W(6), .INIT_FILE(""), .OUT_REG(1)) dut2 (
        .clka   (clka),
        .rsta_n (rsta_n),
        .bus    (bus2)
    );

    logic [31:0] model_mem [64];
    logic [31:0] exp_dout;
    logic [31:0] exp_dout2;
    bit          check_en = 1'b0;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // One clock: present inputs, take the edge, then advance the model by its rules.
    task automatic cycle(input logic we, input logic [5:0] a, input logic [31:0] d);
        bus.wea   = we;
        bus.addra = a;
        bus.dina  = d;
        @(posedge clka);
        if (rsta_n) begin
            exp_dout2 = exp_dout;
            if (we) begin
                model_mem[a] = d;
                exp_dout     = d;
            end else begin
                exp_dout = model_mem[a];
            end
        end
        #1;
    endtask

    always @(negedge clka) begin
        if (check_en) begin
            check("douta", bus.douta, exp_dout);
            check("douta_outreg", bus2.douta, exp_dout2);
        end
    end

    initial begin
        logic [5:0] bb_addrs [6];
        bb_addrs = '{6'd3, 6'd5, 6'd8, 6'd9, 6'd10, 6'd12};
        foreach (model_mem[i]) model_mem[i] = 32'h0;
        exp_dout  = 32'h0;
        exp_dout2 = 32'h0;
        bus.wea   = 1'b0;
        bus.addra = '0;
        bus.dina  = '0;
        check_en  = 1'b1;

        // Reset, then read the untouched low words.
        cycle(1'b0, 6'd0, 32'h0);
        cycle(1'b0, 6'd0, 32'h0);
        check("reset_douta", bus.douta, 32'h0);
        rsta_n = 1'b1;
        for (int a = 0; a <= 10; a++) cycle(1'b0, 6'(a), 32'h0);
        check("init_word10", bus.douta, 32'h0);

        // Write pattern and read back 0..12.
        cycle(1'b1, 6'd1, 32'hAAAAAAAA);
        foreach (bb_addrs[i]) cycle(1'b1, bb_addrs[i], 32'hBBBBBBBB);
        for (int a = 0; a <= 12; a++) begin
            cycle(1'b0, 6'(a), 32'h0);
            if (a == 4) check("rd_word4", bus.douta, 32'h0);
            if (a == 5) check("rd_word5", bus.douta, 32'hBBBBBBBB);
        end

        // Write-first: data appears on the port from the write edge.
        cycle(1'b1, 6'd7, 32'h12345678);
        check("write_first", bus.douta, 32'h12345678);

        // Overwrite word 1, neighbour untouched.
        cycle(1'b1, 6'd1, 32'hAAAAAAAA);
        cycle(1'b1, 6'd1, 32'h55555555);
        cycle(1'b0, 6'd1, 32'h0);
        check("overwrite_w1", bus.douta, 32'h55555555);
        cycle(1'b0, 6'd3, 32'h0);
        check("keep_w3", bus.douta, 32'hBBBBBBBB);

        // Asynchronous reset between edges; array survives.
        cycle(1'b0, 6'd8, 32'h0);
        check("pre_reset", bus.douta, 32'hBBBBBBBB);
        #2;
        rsta_n    = 1'b0;
        exp_dout  = 32'h0;
        exp_dout2 = 32'h0;
        #1;
        check("async_clear", bus.douta, 32'h0);
        check("async_clear_outreg", bus2.douta, 32'h0);
        cycle(1'b0, 6'd8, 32'h0);
        rsta_n = 1'b1;
        cycle(1'b0, 6'd8, 32'h0);
        check("post_reset_w8", bus.douta, 32'hBBBBBBBB);

        // Boundary addresses, no aliasing between 0 and 63.
        cycle(1'b1, 6'd63, 32'hDEADBEEF);
        cycle(1'b1, 6'd0, 32'hCAFEF00D);
        cycle(1'b0, 6'd63, 32'h0);
        check("rd_w63", bus.douta, 32'hDEADBEEF);
        cycle(1'b0, 6'd0, 32'h0);
        check("rd_w0", bus.douta, 32'hCAFEF00D);
        check("rd_w63_outreg", bus2.douta, 32'hDEADBEEF);

        // Random traffic, concentrated on a few addresses to force reuse.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] a;
            a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                            : 6'($urandom_range(0, 7) * 9);
            cycle(1'($urandom_range(0, 1)), a, $urandom);
        end

        @(negedge clka);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_data_ram_b
